// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the uart receive buffer: default sizing, io register map
// and the layout of the status register.
`ifndef UART_RX_FIFO_DEPTH
`define UART_RX_FIFO_DEPTH 16
`endif
`ifndef UART_RX_FIFO_THRESH
`define UART_RX_FIFO_THRESH 8
`endif

package uart_rx_fifo_pkg;

  localparam int unsigned UartRxFifoDepth  = `UART_RX_FIFO_DEPTH;
  localparam int unsigned UartRxFifoThresh = `UART_RX_FIFO_THRESH;

  // io addresses of the registers that expose the buffer to the CPU
  localparam logic [7:0] IoAddrRxData   = 8'h20;
  localparam logic [7:0] IoAddrRxStatus = 8'h21;
  localparam logic [7:0] IoAddrRxCount  = 8'h22;

  typedef struct packed {
    logic overflow;
    logic level_hit;
    logic full;
    logic empty;
  } rx_status_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the uart receiver and io: first-word-fall-through,
// fill count, programmable level flag and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = UartRxFifoDepth,
  parameter int unsigned THRESH = UartRxFifoThresh
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clr_ovf,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       level_hit,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ThreshCnt = (AW+1)'(THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCnt);
  assign count     = count_q;
  assign level_hit = (count_q >= ThreshCnt);
  assign overflow  = overflow_q;
  assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop on a full buffer frees the slot the simultaneous push needs.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = rx_done && (!full || do_pop) && !flush;
  assign drop    = rx_done && full && !do_pop && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop | (overflow_q & ~clr_ovf);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_done, pop, flush, clr_ovf;
  logic [7:0]    dout;
  logic          empty, full, level_hit, overflow;
  logic [AW:0]   count;

  logic [7:0] model_q[$];
  bit         model_ovf;
  int         n_checks = 0;
  int         n_fails  = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .pop       (pop),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .level_hit (level_hit),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = model_q.size();
    check_eq("count", 32'(count), n);
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("level_hit", 32'(level_hit), 32'(n >= THRESH));
    check_eq("overflow", 32'(overflow), 32'(model_ovf));
    check_eq("dout", 32'(dout), (n == 0) ? 32'h0 : 32'(model_q[0]));
  endtask

  // One clock of stimulus; the model follows the buffer's documented rules.
  task automatic step(input bit push, input logic [7:0] d, input bit p, input bit fl,
                      input bit co);
    bit popped, dropped;
    rx_done = push; rx_data = d; pop = p; flush = fl; clr_ovf = co;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      if (co) model_ovf = 1'b0;
    end else begin
      popped  = p && (model_q.size() > 0);
      dropped = push && (model_q.size() == DEPTH) && !popped;
      if (popped) void'(model_q.pop_front());
      if (push && !dropped) model_q.push_back(d);
      if (dropped) model_ovf = 1'b1;
      else if (co) model_ovf = 1'b0;
    end
    #1;
    rx_done = 1'b0; pop = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; pop = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    model_ovf = 1'b0;
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 0);

    // Three bytes in, three out in order.
    step(1, 8'h41, 0, 0, 0);
    check_eq("fwft_first", 32'(dout), 32'h41);
    step(1, 8'h42, 0, 0, 0);
    step(1, 8'h43, 0, 0, 0);
    check_eq("count3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("drain_abc", 32'(dout), 32'h41 + i);
      step(0, 8'h00, 1, 0, 0);
    end
    check_eq("empty_dout", 32'(dout), 32'h0);

    // Overfill by one, drain, then clear overflow.
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 15) check_eq("full16", 32'(full), 32'd1);
    end
    check_eq("ovf17", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_seq", 32'(dout), 32'(i));
      step(0, 8'h00, 1, 0, 0);
    end
    step(0, 8'h00, 0, 0, 1);
    check_eq("clr_ovf", 32'(overflow), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    check_eq("full_pushpop_cnt", 32'(count), 32'd16);
    check_eq("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("last_aa", 32'(dout), 32'hAA);
      step(0, 8'h00, 1, 0, 0);
    end

    // Level flag, then flush racing a push, with overflow set beforehand.
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    check_eq("level_on", 32'(level_hit), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    check_eq("level_off", 32'(level_hit), 32'd0);
    for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0, 0);
    check_eq("ovf_before_flush", 32'(overflow), 32'd1);
    step(1, 8'h55, 0, 1, 0);
    check_eq("flush_cnt", 32'(count), 32'd0);
    check_eq("flush_ovf", 32'(overflow), 32'd1);
    step(1, 8'h66, 0, 0, 1);  // push plus clear: overflow clears, byte kept
    step(0, 8'h00, 1, 0, 0);
    // Full plus clr_ovf plus a dropped push: set wins.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'h77, 0, 0, 1);
    check_eq("set_wins", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1, 1);

    // Asynchronous reset with five bytes held and a push in flight.
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    #2;
    rx_done = 1'b1; rx_data = 8'hEE;
    rst_n = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1, 0, 0);
    check_eq("pop_empty_cnt", 32'(count), 32'd0);

    // Pointer wrap over 40 push/pop pairs.
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h30 + i), 0, 0, 0);
      check_eq("wrap_dout", 32'(dout), 32'(8'(8'h30 + i)));
      step(0, 8'h00, 1, 0, 0);
    end

    // Randomized phases: fill-heavy, drain-heavy and balanced.
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned push_pct, pop_pct;
      push_pct = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 25 : 55;
      pop_pct  = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 80 : 50;
      for (int c = 0; c < 150; c++) begin
        step(($urandom_range(99) < push_pct), 8'($urandom), ($urandom_range(99) < pop_pct),
             ($urandom_range(99) < 2), ($urandom_range(99) < 4));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
